// File: rtl/dice_roller_if.sv
// Player-facing signal bundle of the dice roller: enable, raw buttons, die values and rolled flags.
interface dice_roller_if;
   logic       ena;
   logic       btn1;
   logic       btn2;
   logic [2:0] dice1;
   logic [2:0] dice2;
   logic       rolled1;
   logic       rolled2;

   modport master (
      output ena, btn1, btn2,
      input  dice1, dice2, rolled1, rolled2
   );

   modport slave (
      input  ena, btn1, btn2,
      output dice1, dice2, rolled1, rolled2
   );
endinterface

// File: rtl/dice_roller.sv
// Two-player dice roller: sync + debounce per button, per-player roll FSM, shared round clear.
// Optional macro DICE_LFSR_EN adds a free-running LFSR that makes each roll step +1 or +2.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_WAIT    | no value this round, waiting for a debounced press
// ST_ROLLING | button held, die advances every enabled cycle
// ST_DONE    | value frozen; a press clears the round once both are done
module dice_roller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   dice_roller_if.slave bus
);

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_ROLLING = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync_a_q, sync_a_d;
   logic [1:0] sync_b_q, sync_b_d;
   logic [1:0] db_q, db_d;
   logic [1:0] db_prev_q, db_prev_d;
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];
   state_e     state_q [2];
   state_e     state_d [2];
   logic [2:0] dice_q [2];
   logic [2:0] dice_d [2];

   logic [1:0] press_ev;
   logic [1:0] rel_ev;
   logic [1:0] step_two;
   logic       both_done;

   // +1 or +2 with the result kept in 1..6
   function automatic logic [2:0] next_face(input logic [2:0] face, input logic two);
      logic [3:0] sum;
      sum = {1'b0, face} + (two ? 4'd2 : 4'd1);
      if (sum > 4'd6) begin
         sum = sum - 4'd6;
      end
      return sum[2:0];
   endfunction

`ifdef DICE_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb;

   assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign lfsr_d   = bus.ena ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
   assign step_two = lfsr_q[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign step_two = 2'b00;
`endif

   assign press_ev  = db_q & ~db_prev_q;
   assign rel_ev    = ~db_q & db_prev_q;
   assign both_done = (state_q[0] == ST_DONE) && (state_q[1] == ST_DONE);

   always_comb begin
      sync_a_d  = sync_a_q;
      sync_b_d  = sync_b_q;
      db_d      = db_q;
      db_prev_d = db_prev_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i]   = cnt_q[i];
         state_d[i] = state_q[i];
         dice_d[i]  = dice_q[i];
      end

      if (bus.ena) begin
         sync_a_d  = {bus.btn2, bus.btn1};
         sync_b_d  = sync_a_q;
         db_prev_d = db_q;

         for (int i = 0; i < 2; i++) begin
            if (sync_b_q[i] == db_q[i]) begin
               cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_TC) begin
               db_d[i]  = sync_b_q[i];
               cnt_d[i] = 8'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end

            case (state_q[i])
               ST_WAIT: begin
                  if (press_ev[i]) begin
                     state_d[i] = ST_ROLLING;
                     dice_d[i]  = next_face(dice_q[i], step_two[i]);
                  end
               end
               ST_ROLLING: begin
                  if (rel_ev[i]) begin
                     state_d[i] = ST_DONE;
                  end else begin
                     dice_d[i] = next_face(dice_q[i], step_two[i]);
                  end
               end
               ST_DONE: begin
                  // Either player's press clears both, but only once both are done
                  if (both_done && (press_ev != 2'b00)) begin
                     state_d[i] = ST_WAIT;
                  end
               end
               default: state_d[i] = ST_WAIT;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a_q  <= 2'b00;
         sync_b_q  <= 2'b00;
         db_q      <= 2'b00;
         db_prev_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i]   <= 8'd0;
            state_q[i] <= ST_WAIT;
            dice_q[i]  <= 3'd1;
         end
      end else begin
         sync_a_q  <= sync_a_d;
         sync_b_q  <= sync_b_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
            dice_q[i]  <= dice_d[i];
         end
      end
   end

   assign bus.dice1   = dice_q[0];
   assign bus.dice2   = dice_q[1];
   assign bus.rolled1 = (state_q[0] == ST_DONE);
   assign bus.rolled2 = (state_q[1] == ST_DONE);

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller (DEBOUNCE_CYCLES = 4, default build): expected outputs are queued
// when stimulus is applied and popped/compared once the corresponding response is due.
module tb_dice_roller;

   localparam int DB  = 4;
   localparam int LAT = 2 + DB + 1;

   typedef struct packed {
      logic [2:0] d1;
      logic [2:0] d2;
      logic       r1;
      logic       r2;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb[$];

   dice_roller_if bus ();

   dice_roller #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [2:0] face_after(input int start, input int n);
      int f;
      f = ((start - 1 + n) % 6) + 1;
      return f[2:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [2:0] d1, input logic [2:0] d2,
                           input logic r1, input logic r2);
      exp_t e;
      e.tag = tag;
      e.v   = '{d1: d1, d2: d2, r1: r1, r2: r2};
      sb.push_back(e);
   endtask

   task automatic check_next();
      exp_t e;
      obs_t o;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         e = sb.pop_front();
         o = '{d1: bus.dice1, d2: bus.dice2, r1: bus.rolled1, r2: bus.rolled2};
         assert (o === e.v) else begin
            errors++;
            $error("FAIL %s: observed d1=%0d d2=%0d r1=%0b r2=%0b expected d1=%0d d2=%0d r1=%0b r2=%0b",
                   e.tag, o.d1, o.d2, o.r1, o.r2, e.v.d1, e.v.d2, e.v.r1, e.v.r2);
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      bus.ena  = 1'b1;
      bus.btn1 = 1'b1;
      bus.btn2 = 1'b1;

      // reset with both buttons held
      push_exp("reset", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(2);
      check_next();
      rst_n    = 1'b1;
      bus.btn1 = 1'b0;
      bus.btn2 = 1'b0;
      push_exp("idle_after_reset", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(15);
      check_next();

      // bouncing button never persists long enough
      for (int k = 0; k < 4; k++) begin
         bus.btn1 = 1'b1;
         tick(3);
         bus.btn1 = 1'b0;
         tick(3);
      end
      push_exp("bounce", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(10);
      check_next();

      // player 1 rolls: held 20 cycles
      bus.btn1 = 1'b1;
      push_exp("roll1_pre", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(LAT - 1);
      check_next();
      push_exp("roll1_enter", face_after(1, 1), 3'd1, 1'b0, 1'b0);
      tick(1);
      check_next();
      tick(20 - LAT);
      bus.btn1 = 1'b0;
      push_exp("roll1_before_done", face_after(1, 20), 3'd1, 1'b0, 1'b0);
      tick(LAT - 1);
      check_next();
      push_exp("roll1_done", face_after(1, 20), 3'd1, 1'b1, 1'b0);
      tick(1);
      check_next();

      // player 1 press while player 2 not done is ignored
      bus.btn1 = 1'b1;
      tick(12);
      bus.btn1 = 1'b0;
      push_exp("ignore", face_after(1, 20), 3'd1, 1'b1, 1'b0);
      tick(12);
      check_next();

      // player 2 rolls: held 9 cycles
      bus.btn2 = 1'b1;
      tick(9);
      bus.btn2 = 1'b0;
      push_exp("roll2_done", face_after(1, 20), face_after(1, 9), 1'b1, 1'b1);
      tick(LAT);
      check_next();

      // clearing press on btn2
      bus.btn2 = 1'b1;
      push_exp("clear_pre", face_after(1, 20), face_after(1, 9), 1'b1, 1'b1);
      tick(LAT - 1);
      check_next();
      push_exp("clear", face_after(1, 20), face_after(1, 9), 1'b0, 1'b0);
      tick(1);
      check_next();
      bus.btn2 = 1'b0;
      push_exp("clear_release", face_after(1, 20), face_after(1, 9), 1'b0, 1'b0);
      tick(15);
      check_next();

      // roll with an enable gap
      bus.btn1 = 1'b1;
      push_exp("ena_enter", face_after(3, 1), face_after(1, 9), 1'b0, 1'b0);
      tick(LAT);
      check_next();
      push_exp("ena_rolling", face_after(3, 4), face_after(1, 9), 1'b0, 1'b0);
      tick(3);
      check_next();
      bus.ena = 1'b0;
      push_exp("ena_frozen", face_after(3, 4), face_after(1, 9), 1'b0, 1'b0);
      tick(10);
      check_next();
      bus.ena = 1'b1;
      push_exp("ena_resumed", face_after(3, 6), face_after(1, 9), 1'b0, 1'b0);
      tick(2);
      check_next();

      // reset in the middle of a roll
      rst_n    = 1'b0;
      bus.btn1 = 1'b0;
      push_exp("reset_midroll", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(1);
      check_next();
      rst_n = 1'b1;
      push_exp("after_midroll_reset", 3'd1, 3'd1, 1'b0, 1'b0);
      tick(15);
      check_next();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Upstream stage of the game's result/display decode logic.
- Turns two raw player push-buttons into two stable die values (1..6) and per-player "rolled" flags, which feed the display decoder directly.
- Each player holds a button to spin a die and releases it to freeze the value.
- Once both players have rolled, the next press clears the round.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clock edges a synchronized button level must persist before it is accepted. Legal range 2..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- ena  input  1  clock enable. When low, all state is frozen (sync, debounce, counters, FSMs).
- btn1  input  1  raw player-1 button, asynchronous, active-high.
- btn2  input  1  raw player-2 button, asynchronous, active-high.
- dice1  output  3  player-1 die value, always 1..6.
- dice2  output  3  player-2 die value, always 1..6.
- rolled1  output  1  player-1 has a frozen value for this round.
- rolled2  output  1  player-2 has a frozen value for this round.

Behaviour:
- Reset (rst_n low at a clk edge):
  - dice1 = dice2 = 3'd1; rolled1 = rolled2 = 0.
  - Sync flops, debounced levels and debounce counters = 0.
  - Both player FSMs go to WAIT.
  - Applies mid-roll too: a ROLLING player returns to WAIT with dice = 1.
- Synchronizer: btnX passes through 2 flops giving sX.
- Debounce:
  - Counter counts edges where sX != dbX; it clears whenever sX == dbX.
  - When sX has differed on DEBOUNCE_CYCLES consecutive edges, dbX <= sX and the counter clears.
  - Press event = dbX 0->1; release event = dbX 1->0, each lasting one cycle.
- Player FSM (per player, identical):
  - WAIT (rolledX = 0): on press -> ROLLING.
  - ROLLING (rolledX = 0):
    - diceX advances every enabled cycle: 1,2,3,4,5,6,1...
    - Advance occurs on the edge that enters ROLLING and on every edge while in it.
    - On release -> DONE; value frozen at that edge (the release edge does not advance).
  - DONE (rolledX = 1): press events are ignored while the other player is not DONE.
- Round clear:
  - When both FSMs are DONE, a press on either button (or both in the same cycle) sends both FSMs to WAIT on that edge.
  - rolled1/rolled2 fall together; the dice hold their values.
  - The clearing press does NOT start a roll. The player must release and press again.
- Value range: dice never 0 or 7. Wrap 6->1 is mandatory.
- Simultaneous presses from WAIT: both players enter ROLLING independently on the same edge.
- A release arriving while in WAIT (e.g. after a clearing press) is ignored.
- Latency: raw btn edge to FSM state change = 2 + DEBOUNCE_CYCLES + 1 edges. All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro DICE_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) free-runs on every enabled cycle.
  - In ROLLING, each die steps by 1 if lfsr[0] = 0 and by 2 if lfsr[0] = 1, with mod-6 wrap kept in 1..6 (5+2 -> 1, 6+2 -> 2).
  - Player 2 uses lfsr[1] instead.
- Undefined: no LFSR logic; step is always 1.

Test Plan:
- Reset: rst_n = 0 for 2 edges with buttons high -> dice1 = dice2 = 1, rolled1 = rolled2 = 0. No roll after reset deasserts until a fresh debounced press.
- Roll (DEBOUNCE_CYCLES = 4, macro off):
  - Stimulus: btn1 high 20 cycles, then low.
  - Expected: rolled1 rises exactly 7 edges after the btn1 fall; dice1 equals the model value (1 + accepted ROLLING cycles) mod 6 mapped to 1..6; rolled2 = 0.
- Bounce: 3-cycle btn1 pulses separated by 3 low cycles (DEBOUNCE_CYCLES = 4) -> no FSM change; dice1 stays 1.
- Ignore:
  - Stimulus: rolled1 = 1, rolled2 = 0, press/release btn1.
  - Expected: dice1 and rolled1 unchanged. Then roll player 2 -> rolled2 = 1.
- Clear and ena:
  - With both rolled, press btn2 -> both rolled fall on the same edge, dice unchanged. Releasing btn2 leaves rolled2 = 0.
  - In ROLLING, ena = 0 for 10 cycles -> dice frozen.
  - rst_n low mid-roll -> dice = 1, rolled = 0.
- LFSR (macro on): hold btn1 50 cycles -> every observed step is +1 or +2 mod 6, matching the model LFSR sequence from seed ACE1; dice never 0 or 7.
